// File: rtl/motor_mixer_pkg.sv
// Shared types and constants for the motor mixer: FSM state encoding,
// the 11-bit motor speed type and the default speed constants.
package flight_pkg;

  typedef logic [10:0] speed_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    SPINUP   = 2'd1,
    RUN      = 2'd2,
    CAL      = 2'd3
  } mixer_state_t;

  localparam logic [12:0] MIN_RUN_SPEED = 13'h2C0;
  localparam speed_t      CAL_SPEED     = 11'h290;
  localparam speed_t      SPIN_STEP     = 11'h010;
  localparam speed_t      SLEW_STEP     = 11'h020;

  // Spin-up target expressed in the motor speed width.
  localparam speed_t      MIN_RUN_SPD11 = MIN_RUN_SPEED[10:0];

endpackage

// File: rtl/motor_mixer_if.sv
// Bus between the PD stage / thrust source and the motor mixer.
// master drives PD terms, thrust and mode levels; slave returns motor speeds.
interface motor_mixer_if;
  import flight_pkg::*;

  logic              vld;
  logic              armed;
  logic              inertial_cal;
  logic [8:0]        thrst;
  logic signed [9:0] ptch_pterm;
  logic signed [11:0] ptch_dterm;
  logic signed [9:0] roll_pterm;
  logic signed [11:0] roll_dterm;
  logic signed [9:0] yaw_pterm;
  logic signed [11:0] yaw_dterm;
  speed_t            frnt_spd;
  speed_t            bck_spd;
  speed_t            lft_spd;
  speed_t            rght_spd;
  logic              spd_vld;

  modport master (
    output vld, armed, inertial_cal, thrst,
    output ptch_pterm, ptch_dterm, roll_pterm, roll_dterm, yaw_pterm, yaw_dterm,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
  );

  modport slave (
    input  vld, armed, inertial_cal, thrst,
    input  ptch_pterm, ptch_dterm, roll_pterm, roll_dterm, yaw_pterm, yaw_dterm,
    output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
  );

endinterface

// File: rtl/motor_mixer_mix_sat.sv
// mix_sat: one motor's mix. Sums idle speed, thrust, one axis P/D pair and the
// yaw P/D pair (each pair with a selectable sign) in 13-bit two's complement,
// then saturates to an unsigned 11-bit speed. Purely combinational.
module mix_sat
  import flight_pkg::*;
(
  input  logic [8:0]         thrst,
  input  logic signed [9:0]  axis_pterm,
  input  logic signed [11:0] axis_dterm,
  input  logic signed [9:0]  yaw_pterm,
  input  logic signed [11:0] yaw_dterm,
  input  logic               axis_neg,
  input  logic               yaw_neg,
  output speed_t             spd
);

  logic [12:0] axis_s;
  logic [12:0] yaw_s;
  logic [12:0] axis_term_s;
  logic [12:0] yaw_term_s;
  logic [12:0] sum_s;

  // Sign-extend, combine each P/D pair, apply per-motor signs, sum and saturate.
  always_comb begin
    axis_s      = {{3{axis_pterm[9]}}, axis_pterm} + {axis_dterm[11], axis_dterm};
    yaw_s       = {{3{yaw_pterm[9]}}, yaw_pterm} + {yaw_dterm[11], yaw_dterm};
    axis_term_s = axis_neg ? (13'd0 - axis_s) : axis_s;
    yaw_term_s  = yaw_neg ? (13'd0 - yaw_s) : yaw_s;
    sum_s       = MIN_RUN_SPEED + {4'b0000, thrst} + axis_term_s + yaw_term_s;
    if (sum_s[12]) begin
      spd = 11'h000;
    end else if (sum_s[11]) begin
      spd = 11'h7FF;
    end else begin
      spd = sum_s[10:0];
    end
  end

endmodule

// File: rtl/motor_mixer.sv
// motor_mixer: two-stage pipeline from PD terms + thrust to four motor speeds.
// Stage 1 registers the inputs; stage 2 steps the arm/spin-up/calibrate FSM
// and registers the speeds with a one-cycle spd_vld.
// Optional feature macro: MOTOR_SLEW_LIMIT_EN (limits per-update speed change in RUN).
module motor_mixer
  import flight_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  motor_mixer_if.slave bus
);

  // Stage-1 registers
  logic               vld1_r;
  logic               armed1_r;
  logic               cal1_r;
  logic [8:0]         thrst1_r;
  logic signed [9:0]  ptch_p1_r;
  logic signed [11:0] ptch_d1_r;
  logic signed [9:0]  roll_p1_r;
  logic signed [11:0] roll_d1_r;
  logic signed [9:0]  yaw_p1_r;
  logic signed [11:0] yaw_d1_r;

  // Stage-2 state and outputs (index 0 frnt, 1 bck, 2 lft, 3 rght)
  mixer_state_t state_r;
  mixer_state_t state_nxt_s;
  speed_t       ramp_r;
  speed_t       ramp_nxt_s;
  speed_t       ramp_clamp_s;
  logic [11:0]  ramp_sum_s;
  speed_t       spd_r     [4];
  speed_t       spd_nxt_s [4];
  speed_t       mix_s     [4];
  logic         spd_vld_r;

`ifdef MOTOR_SLEW_LIMIT_EN
  // Move cur toward tgt by at most SLEW_STEP.
  function automatic speed_t slew_toward(input speed_t cur, input speed_t tgt);
    logic [11:0] up_s;
    up_s = {1'b0, cur} + {1'b0, SLEW_STEP};
    if ({1'b0, tgt} > up_s) begin
      return up_s[10:0];
    end else if (({1'b0, tgt} + {1'b0, SLEW_STEP}) < {1'b0, cur}) begin
      return cur - SLEW_STEP;
    end else begin
      return tgt;
    end
  endfunction
`endif

  // Stage 1: capture every input each cycle; only vld1_r qualifies its use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_r    <= 1'b0;
      armed1_r  <= 1'b0;
      cal1_r    <= 1'b0;
      thrst1_r  <= 9'd0;
      ptch_p1_r <= 10'sd0;
      ptch_d1_r <= 12'sd0;
      roll_p1_r <= 10'sd0;
      roll_d1_r <= 12'sd0;
      yaw_p1_r  <= 10'sd0;
      yaw_d1_r  <= 12'sd0;
    end else begin
      vld1_r    <= bus.vld;
      armed1_r  <= bus.armed;
      cal1_r    <= bus.inertial_cal;
      thrst1_r  <= bus.thrst;
      ptch_p1_r <= bus.ptch_pterm;
      ptch_d1_r <= bus.ptch_dterm;
      roll_p1_r <= bus.roll_pterm;
      roll_d1_r <= bus.roll_dterm;
      yaw_p1_r  <= bus.yaw_pterm;
      yaw_d1_r  <= bus.yaw_dterm;
    end
  end

  mix_sat u_mix_frnt (
    .thrst(thrst1_r), .axis_pterm(ptch_p1_r), .axis_dterm(ptch_d1_r),
    .yaw_pterm(yaw_p1_r), .yaw_dterm(yaw_d1_r),
    .axis_neg(1'b0), .yaw_neg(1'b1), .spd(mix_s[0])
  );

  mix_sat u_mix_bck (
    .thrst(thrst1_r), .axis_pterm(ptch_p1_r), .axis_dterm(ptch_d1_r),
    .yaw_pterm(yaw_p1_r), .yaw_dterm(yaw_d1_r),
    .axis_neg(1'b1), .yaw_neg(1'b1), .spd(mix_s[1])
  );

  mix_sat u_mix_lft (
    .thrst(thrst1_r), .axis_pterm(roll_p1_r), .axis_dterm(roll_d1_r),
    .yaw_pterm(yaw_p1_r), .yaw_dterm(yaw_d1_r),
    .axis_neg(1'b0), .yaw_neg(1'b0), .spd(mix_s[2])
  );

  mix_sat u_mix_rght (
    .thrst(thrst1_r), .axis_pterm(roll_p1_r), .axis_dterm(roll_d1_r),
    .yaw_pterm(yaw_p1_r), .yaw_dterm(yaw_d1_r),
    .axis_neg(1'b1), .yaw_neg(1'b0), .spd(mix_s[3])
  );

  // Next state, ramp and speeds; outputs always follow the destination state.
  always_comb begin
    state_nxt_s  = state_r;
    ramp_nxt_s   = ramp_r;
    for (int i = 0; i < 4; i++) begin
      spd_nxt_s[i] = spd_r[i];
    end
    ramp_sum_s   = {1'b0, ramp_r} + {1'b0, SPIN_STEP};
    ramp_clamp_s = (ramp_sum_s >= {1'b0, MIN_RUN_SPD11}) ? MIN_RUN_SPD11 : ramp_sum_s[10:0];

    if (cal1_r) begin
      state_nxt_s = CAL;
      ramp_nxt_s  = 11'h000;
      for (int i = 0; i < 4; i++) begin
        spd_nxt_s[i] = CAL_SPEED;
      end
    end else if ((state_r == CAL) || !armed1_r) begin
      state_nxt_s = DISARMED;
      ramp_nxt_s  = 11'h000;
      for (int i = 0; i < 4; i++) begin
        spd_nxt_s[i] = 11'h000;
      end
    end else begin
      case (state_r)
        DISARMED, SPINUP: begin
          ramp_nxt_s  = ramp_clamp_s;
          state_nxt_s = (ramp_clamp_s == MIN_RUN_SPD11) ? RUN : SPINUP;
          for (int i = 0; i < 4; i++) begin
            spd_nxt_s[i] = ramp_clamp_s;
          end
        end
        RUN: begin
          for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_SLEW_LIMIT_EN
            spd_nxt_s[i] = slew_toward(spd_r[i], mix_s[i]);
`else
            spd_nxt_s[i] = mix_s[i];
`endif
          end
        end
        default: begin
          state_nxt_s = DISARMED;
          ramp_nxt_s  = 11'h000;
          for (int i = 0; i < 4; i++) begin
            spd_nxt_s[i] = 11'h000;
          end
        end
      endcase
    end
  end

  // Stage 2: commit FSM, ramp and speeds only on a stage-1 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= DISARMED;
      ramp_r    <= 11'h000;
      spd_vld_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spd_r[i] <= 11'h000;
      end
    end else begin
      spd_vld_r <= vld1_r;
      if (vld1_r) begin
        state_r <= state_nxt_s;
        ramp_r  <= ramp_nxt_s;
        for (int i = 0; i < 4; i++) begin
          spd_r[i] <= spd_nxt_s[i];
        end
      end
    end
  end

  assign bus.frnt_spd = spd_r[0];
  assign bus.bck_spd  = spd_r[1];
  assign bus.lft_spd  = spd_r[2];
  assign bus.rght_spd = spd_r[3];
  assign bus.spd_vld  = spd_vld_r;

endmodule

// File: tb/tb_motor_mixer.sv
// Self-checking bench for motor_mixer: directed steps plus a randomized run,
// every cycle compared against a behavioural model of arming, spin-up,
// calibration, mixing and saturation with a two-cycle output delay.
module tb_motor_mixer;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  motor_mixer_if mm_if ();

  motor_mixer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int  m_ramp = 0;
  bit  m_run  = 0;
  bit  m_cal  = 0;
  int  m_spd [4] = '{0, 0, 0, 0};

  // Expected-output pipeline: q0 = driven last negedge, q1 = two negedges ago
  logic        q0_v = 1'b0;
  logic        q1_v = 1'b0;
  logic [43:0] q0_s = '0;
  logic [43:0] q1_s = '0;
  logic [43:0] hold_s = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] dut_spd();
    return {mm_if.frnt_spd, mm_if.bck_spd, mm_if.lft_spd, mm_if.rght_spd};
  endfunction

  function automatic logic [43:0] pack4(input int f, input int b, input int l, input int r);
    return {11'(f), 11'(b), 11'(l), 11'(r)};
  endfunction

  // 13-bit wrap-around arithmetic, then clamp to the 0..2047 speed range.
  function automatic int wrap_sat(input int v);
    int w;
    w = v & 8191;
    if (w >= 4096) w = w - 8192;
    if (w < 0) return 0;
    if (w > 2047) return 2047;
    return w;
  endfunction

  task automatic model_update(input logic a, input logic c, input int t,
                              input int pp, input int pd, input int rp, input int rd,
                              input int yp, input int yd, output logic [43:0] res);
    int tgt [4];
    if (c) begin
      m_cal = 1; m_run = 0; m_ramp = 0;
      for (int i = 0; i < 4; i++) m_spd[i] = 'h290;
    end else if (m_cal || !a) begin
      m_cal = 0; m_run = 0; m_ramp = 0;
      for (int i = 0; i < 4; i++) m_spd[i] = 0;
    end else if (m_run) begin
      tgt[0] = wrap_sat(704 + t + pp + pd - yp - yd);
      tgt[1] = wrap_sat(704 + t - pp - pd - yp - yd);
      tgt[2] = wrap_sat(704 + t + rp + rd + yp + yd);
      tgt[3] = wrap_sat(704 + t - rp - rd + yp + yd);
      for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_SLEW_LIMIT_EN
        if (tgt[i] > m_spd[i] + 32) m_spd[i] = m_spd[i] + 32;
        else if (tgt[i] < m_spd[i] - 32) m_spd[i] = m_spd[i] - 32;
        else m_spd[i] = tgt[i];
`else
        m_spd[i] = tgt[i];
`endif
      end
    end else begin
      m_ramp = (m_ramp + 16 > 704) ? 704 : m_ramp + 16;
      m_run  = (m_ramp == 704);
      for (int i = 0; i < 4; i++) m_spd[i] = m_ramp;
    end
    res = pack4(m_spd[0], m_spd[1], m_spd[2], m_spd[3]);
  endtask

  // One clock cycle: check outputs for the update driven two cycles ago, then drive.
  task automatic cyc(input logic v, input logic a, input logic c, input logic [8:0] t,
                     input logic signed [9:0] pp, input logic signed [11:0] pd,
                     input logic signed [9:0] rp, input logic signed [11:0] rd,
                     input logic signed [9:0] yp, input logic signed [11:0] yd);
    logic [43:0] res;
    @(negedge clk);
    if (q1_v) hold_s = q1_s;
    chk("spd_vld", {63'd0, mm_if.spd_vld}, {63'd0, q1_v});
    chk("speeds", {20'd0, dut_spd()}, {20'd0, hold_s});
    q1_v = q0_v;
    q1_s = q0_s;
    mm_if.vld = v; mm_if.armed = a; mm_if.inertial_cal = c; mm_if.thrst = t;
    mm_if.ptch_pterm = pp; mm_if.ptch_dterm = pd;
    mm_if.roll_pterm = rp; mm_if.roll_dterm = rd;
    mm_if.yaw_pterm = yp;  mm_if.yaw_dterm = yd;
    q0_v = v;
    if (v) begin
      model_update(a, c, int'(t), int'(pp), int'(pd), int'(rp), int'(rd), int'(yp), int'(yd), res);
      q0_s = res;
    end
  endtask

  task automatic idle2(input logic a);
    cyc(1'b0, a, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    cyc(1'b0, a, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
  endtask

  task automatic model_reset();
    m_ramp = 0; m_run = 0; m_cal = 0;
    for (int i = 0; i < 4; i++) m_spd[i] = 0;
    q0_v = 1'b0; q1_v = 1'b0; hold_s = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    mm_if.vld = 1'b0; mm_if.armed = 1'b0; mm_if.inertial_cal = 1'b0; mm_if.thrst = 9'd0;
    mm_if.ptch_pterm = 10'sd0; mm_if.ptch_dterm = 12'sd0;
    mm_if.roll_pterm = 10'sd0; mm_if.roll_dterm = 12'sd0;
    mm_if.yaw_pterm = 10'sd0;  mm_if.yaw_dterm = 12'sd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_speeds", {20'd0, dut_spd()}, 64'd0);
    chk("reset_vld", {63'd0, mm_if.spd_vld}, 64'd0);
    rst_n = 1'b1;

    // Disarmed updates with random terms keep motors at zero
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 9'($urandom), 10'($urandom), 12'($urandom),
          10'($urandom), 12'($urandom), 10'($urandom), 12'($urandom));
      idle2(1'b0);
    end
    chk("disarmed_zero", {20'd0, dut_spd()}, 64'd0);

    // Spin-up: first update gives one step, 44 updates reach idle speed
    cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("spin_first", {20'd0, dut_spd()}, {20'd0, pack4('h010, 'h010, 'h010, 'h010)});
    for (int k = 0; k < 43; k++)
      cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("spin_last", {20'd0, dut_spd()}, {20'd0, pack4('h2C0, 'h2C0, 'h2C0, 'h2C0)});

`ifdef MOTOR_SLEW_LIMIT_EN
    // Slewed approach 0x2C0 -> 0x3C0 in 0x20 steps
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 9'h100, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
      idle2(1'b1);
      chk("slew_step", {20'd0, dut_spd()},
          {20'd0, pack4('h2C0 + 32 * k, 'h2C0 + 32 * k, 'h2C0 + 32 * k, 'h2C0 + 32 * k)});
    end
`else
    cyc(1'b1, 1'b1, 1'b0, 9'h100, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("run_thrust", {20'd0, dut_spd()}, {20'd0, pack4('h3C0, 'h3C0, 'h3C0, 'h3C0)});
    cyc(1'b1, 1'b1, 1'b0, 9'h1FF, 10'sh1FF, 12'sh7FF, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("run_saturate", {20'd0, dut_spd()}, {20'd0, pack4('h7FF, 'h000, 'h4BF, 'h4BF)});
    cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sh3F0, 12'sd0, 10'sd0, 12'sd0, 10'sh3F0, 12'sd0);
    cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sh3F0, 12'sd0);
    idle2(1'b1);
    chk("run_yaw", {20'd0, dut_spd()}, {20'd0, pack4('h2D0, 'h2D0, 'h2B0, 'h2B0)});
`endif

    // Calibration overrides, then disarm, then spin-up restarts
    cyc(1'b1, 1'b1, 1'b1, 9'h055, 10'sd7, 12'sd9, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("cal_speed", {20'd0, dut_spd()}, {20'd0, pack4('h290, 'h290, 'h290, 'h290)});
    cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("cal_exit", {20'd0, dut_spd()}, 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 9'd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    idle2(1'b1);
    chk("respin", {20'd0, dut_spd()}, {20'd0, pack4('h010, 'h010, 'h010, 'h010)});

    // Randomized run: mostly armed, rare calibration/disarm, random gaps
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          ($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          9'($urandom), 10'($urandom_range(0, 1023)), 12'($urandom_range(0, 4095)),
          10'($urandom_range(0, 1023)), 12'($urandom_range(0, 4095)),
          10'($urandom_range(0, 1023)), 12'($urandom_range(0, 4095)));
    end
    idle2(1'b1);

    // Bring up to RUN with nonzero outputs, then reset mid-burst
    for (int k = 0; k < 46; k++)
      cyc(1'b1, 1'b1, 1'b0, 9'h080, 10'sd0, 12'sd0, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b1, 1'b0, 9'h0A0, 10'sd3, 12'sd5, 10'sd0, 12'sd0, 10'sd0, 12'sd0);
    #2;
    rst_n = 1'b0;
    mm_if.vld = 1'b0;
    model_reset();
    #1;
    chk("rst_speeds", {20'd0, dut_spd()}, 64'd0);
    chk("rst_vld", {63'd0, mm_if.spd_vld}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) idle2(1'b1);
    chk("post_rst_speeds", {20'd0, dut_spd()}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
